onehot_encoder_seq: RTL

Sequential 8-to-3 encoder: the counterpart of the 3-to-8 `decoder`. It captures an 8-bit request vector and emits, one per handshake, the 3-bit binary index `{a,b,c}` of every set bit, lowest index first, until the vector is exhausted. Each emitted index drives `decoder` inputs `a`, `b`, `c` directly, and `decoder.d` then reproduces the served bit as a one-hot value. The block sits between request sources and decoder-driven select logic.

---
 rtl/onehot_encoder_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/onehot_encoder_seq.sv
// Sequential 8-to-3 encoder.
// Captures an 8-bit request vector and emits, one per handshake, the binary
// index {a,b,c} of every set bit, lowest index first, until the vector is
// exhausted. The emitted index is meant to drive a 3-to-8 decoder directly.
module onehot_encoder_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       load,
    output logic       in_ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic       zero_err
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t     state;
    logic [7:0] pend;

    logic [2:0] cur_idx;
    logic [7:0] pend_after;
    logic [2:0] next_idx;
    logic       next_last;
    logic [2:0] cap_idx;
    logic       cap_last;

    // Index of the lowest set bit; returns 0 for an all-zero vector
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the vector is set
    function automatic logic exactly_one(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    assign cur_idx = {a, b, c};

    // Look-ahead for both the capture path and the post-handshake path
    always_comb begin
        pend_after = pend & ~(8'd1 << cur_idx);
        next_idx   = lowest_index(pend_after);
        next_last  = exactly_one(pend_after);
        cap_idx    = lowest_index(d);
        cap_last   = exactly_one(d);
    end

    // Control FSM with all outputs registered; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            last      <= 1'b0;
            zero_err  <= 1'b0;
        end else begin
            zero_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (d != 8'd0) begin
                            pend        <= d;
                            {a, b, c}   <= cap_idx;
                            last        <= cap_last;
                            out_valid   <= 1'b1;
                            in_ready    <= 1'b0;
                            state       <= EMIT;
                        end else begin
                            zero_err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last) begin
                            pend      <= 8'd0;
                            last      <= 1'b0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            pend      <= pend_after;
                            {a, b, c} <= next_idx;
                            last      <= next_last;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pend      <= 8'd0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    last      <= 1'b0;
                end
            endcase
        end
    end

endmodule
